// File: rtl/jackal_clk_en_gen.sv
// ----------------------------------------------------------------------------
// jackal_clk_en_gen
//
// Clock-enable and core-reset generator for the 49.152 MHz PLL domain.
// The PLL lock flag is brought in through a two-flop synchronizer. The core
// reset stays asserted until synchronized lock has been stable for LOCK_HOLD
// cycles. Once running, the block emits single-cycle clock enables:
//   - cen_cpu / cen_cpu_q : integer-divided E/Q quadrature pair (period DIV_INT)
//   - cen_snd             : fractional-accumulator enable, FRAC_NUM pulses
//                           every FRAC_DEN cycles with no long-term drift
//
// Optional feature macro: JACKAL_CEN_PAUSE_EN
//   When defined, a 'pause' input freezes both counters and the accumulator
//   and forces all enables low. Counting resumes with phase preserved.
//   rst_core_n is unaffected by pause.
//
// Parameters:
//   LOCK_HOLD : cycles of stable synchronized lock before release (>= 1)
//   DIV_INT   : CPU enable period in clk cycles (even, >= 4)
//   FRAC_NUM  : fractional enable numerator (1 <= NUM < DEN)
//   FRAC_DEN  : fractional enable denominator (< 2^27)
//
// Ports:
//   clk        in  : 49.152 MHz PLL clock
//   rst_n      in  : asynchronous active-low reset
//   locked     in  : PLL lock flag, asynchronous to clk
//   pause      in  : freeze enables (only with JACKAL_CEN_PAUSE_EN)
//   rst_core_n out : registered core reset, active-low
//   cen_cpu    out : CPU E enable, one-cycle pulse
//   cen_cpu_q  out : CPU Q enable, DIV_INT/2 cycles ahead of cen_cpu
//   cen_snd    out : sound enable, one-cycle pulse
// ----------------------------------------------------------------------------
module jackal_clk_en_gen #(
    parameter int unsigned LOCK_HOLD = 1024,
    parameter int unsigned DIV_INT   = 32,
    parameter int unsigned FRAC_NUM  = 3579545,
    parameter int unsigned FRAC_DEN  = 49152000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic locked,
`ifdef JACKAL_CEN_PAUSE_EN
    input  logic pause,
`endif
    output logic rst_core_n,
    output logic cen_cpu,
    output logic cen_cpu_q,
    output logic cen_snd
);

    localparam int unsigned HOLD_W = $clog2(LOCK_HOLD + 1);
    localparam int unsigned DIV_W  = $clog2(DIV_INT);
    localparam int unsigned ACC_W  = 28;

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LOCK_HOLD);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV_INT - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(DIV_INT / 2 - 1);
    localparam logic [ACC_W-1:0]  ACC_NUM  = ACC_W'(FRAC_NUM);
    localparam logic [ACC_W-1:0]  ACC_DEN  = ACC_W'(FRAC_DEN);

    localparam logic [1:0] ST_WAIT = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // ------------------------------------------------------------------------
    // Lock synchronizer
    // ------------------------------------------------------------------------
    logic sync_1_q;
    logic locked_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1_q <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_1_q <= locked;
            locked_s <= sync_1_q;
        end
    end

    // ------------------------------------------------------------------------
    // Pause qualifier
    // ------------------------------------------------------------------------
    logic paused;

`ifdef JACKAL_CEN_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Lock-hold state machine
    // ------------------------------------------------------------------------
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic [HOLD_W-1:0] hold_inc;

    // Saturating increment: the hold counter never wraps.
    assign hold_inc = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        if (!locked_s) begin
            // Any loss of synchronized lock restarts the whole sequence.
            state_d    = ST_WAIT;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = hold_inc;
                end
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_MAX) begin
                        state_d = ST_RUN;
                    end else begin
                        hold_cnt_d = hold_inc;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d    = ST_WAIT;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Enable generation
    // ------------------------------------------------------------------------
    // 'staying' is true only for cycles that are in RUN and remain in RUN, so
    // enables drop on the same edge that re-asserts the core reset.
    logic staying;
    logic active;

    assign staying = (state_q == ST_RUN) && (state_d == ST_RUN);
    assign active  = staying && !paused;

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] acc_sum;
    logic             acc_wrap;

    // acc < FRAC_DEN < 2^27 and FRAC_NUM < FRAC_DEN, so the sum fits in 28 bits.
    assign acc_sum  = acc_q + ACC_NUM;
    assign acc_wrap = (acc_sum >= ACC_DEN);

    always_comb begin
        div_cnt_d = div_cnt_q;
        acc_d     = acc_q;
        if (!staying) begin
            // Outside RUN (and on the entry edge) both counters sit at zero.
            div_cnt_d = '0;
            acc_d     = '0;
        end else if (active) begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
            acc_d     = acc_wrap ? (acc_sum - ACC_DEN) : acc_sum;
        end
    end

    logic rst_core_d;
    logic cen_cpu_d;
    logic cen_cpu_q_d;
    logic cen_snd_d;

    always_comb begin
        rst_core_d  = (state_d == ST_RUN);
        cen_cpu_d   = active && (div_cnt_q == DIV_LAST);
        cen_cpu_q_d = active && (div_cnt_q == DIV_HALF);
        cen_snd_d   = active && acc_wrap;
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_WAIT;
            hold_cnt_q <= '0;
            div_cnt_q  <= '0;
            acc_q      <= '0;
            rst_core_n <= 1'b0;
            cen_cpu    <= 1'b0;
            cen_cpu_q  <= 1'b0;
            cen_snd    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            div_cnt_q  <= div_cnt_d;
            acc_q      <= acc_d;
            rst_core_n <= rst_core_d;
            cen_cpu    <= cen_cpu_d;
            cen_cpu_q  <= cen_cpu_q_d;
            cen_snd    <= cen_snd_d;
        end
    end

endmodule
